// File: rtl/dm_pkg.sv
// Shared constants for the data-memory access unit:
// DMCtrl encodings, FSM state codes and lane-select widths.
package dm_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef logic [2:0] dm_state_t;

    localparam dm_state_t S_IDLE = 3'd0;
    localparam dm_state_t S_ACC  = 3'd1;
    localparam dm_state_t S_DATA = 3'd2;
    localparam dm_state_t S_WR   = 3'd3;
    localparam dm_state_t S_RESP = 3'd4;

    localparam int LANE_BW = 2;
    localparam int HALF_BW = 1;

    // Encoding/alignment legality; address range is checked by the caller.
    function automatic logic dm_illegal(
        input logic       wr,
        input logic [2:0] ctrl,
        input logic [1:0] off
    );
        logic bad;
        case (ctrl)
            DM_B:    bad = 1'b0;
            DM_BU:   bad = wr;
            DM_H:    bad = off[0];
            DM_HU:   bad = wr | off[0];
            DM_W:    bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// Byte/half-word lane logic: load extraction with sign/zero
// extension, and read-modify-write merge for narrow stores.
module dm_byte_lane
    import dm_pkg::*;
(
    input  logic [2:0]         i_ctrl,
    input  logic [LANE_BW-1:0] i_off,
    input  logic [31:0]        i_rdata,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_ld_data,
    output logic [31:0]        o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [HALF_BW-1:0] w_hsel;

    assign w_hsel = i_off[1];
    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_rdata[{w_hsel, 4'b0000} +: 16];

    always_comb begin
        o_ld_data = i_rdata;
        case (i_ctrl)
            DM_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            DM_BU:   o_ld_data = {24'h0, w_byte};
            DM_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            DM_HU:   o_ld_data = {16'h0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

    always_comb begin
        o_st_word = i_rdata;
        if (i_ctrl == DM_H)
            o_st_word[{w_hsel, 4'b0000} +: 16] = i_wdata[15:0];
        else
            o_st_word[{i_off, 3'b000} +: 8] = i_wdata[7:0];
    end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store unit between the pipeline and a single-port word SRAM;
// narrow stores are done as read-modify-write.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2:0]        req_ctrl,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    dm_state_t         r_state;
    logic              r_wr;
    logic [2:0]        r_ctrl;
    logic [MEM_AW+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [31:0]       r_merged;

    logic        w_accept;
    logic        w_bad;
    logic        w_word_st;
    logic        w_acc;
    logic        w_wr;
    logic [31:0] w_ld;
    logic [31:0] w_st;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_bad     = dm_illegal(req_wr, req_ctrl, req_addr[1:0])
                     || (|(req_addr >> (MEM_AW + 2)));
    assign w_word_st = r_wr && (r_ctrl == DM_W);
    assign w_acc     = (r_state == S_ACC);
    assign w_wr      = (r_state == S_WR);

    dm_byte_lane u_lane (
        .i_ctrl    (r_ctrl),
        .i_off     (r_addr[1:0]),
        .i_rdata   (mem_rdata),
        .i_wdata   (r_wdata),
        .o_ld_data (w_ld),
        .o_st_word (w_st)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wr     <= 1'b0;
            r_ctrl   <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
            r_merged <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_wr     <= req_wr;
                    r_ctrl   <= req_ctrl;
                    r_addr   <= req_addr[MEM_AW+1:0];
                    r_wdata  <= req_wdata;
                    r_err    <= w_bad;
                    r_rdata  <= 32'h0;
                    r_merged <= 32'h0;
                    r_state  <= w_bad ? S_RESP : S_ACC;
                end
                S_ACC:  r_state <= w_word_st ? S_RESP : S_DATA;
                S_DATA: begin
                    if (r_wr) begin
                        r_merged <= w_st;
                        r_state  <= S_WR;
                    end else begin
                        r_rdata <= w_ld;
                        r_state <= S_RESP;
                    end
                end
                S_WR:   r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = rsp_valid ? r_rdata : 32'h0;

    assign mem_en    = w_acc || w_wr;
    assign mem_we    = (w_acc && w_word_st) || w_wr;
    assign mem_addr  = mem_en ? r_addr[MEM_AW+1:2] : '0;

    always_comb begin
        mem_wdata = 32'h0;
        unique case (1'b1)
            w_acc && w_word_st: mem_wdata = r_wdata;
            w_wr:               mem_wdata = r_merged;
            default:            mem_wdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit against a behavioural word SRAM.
module tb_dm_access_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [2:0]    req_ctrl;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0] mem [0:(1<<AW)-1];
    int nrd = 0;
    int nwr = 0;
    int nviol = 0;
    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    dm_access_unit #(.MEM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_ctrl(req_ctrl),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            nwr++;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            nrd++;
        end
    end

    always @(negedge clk) begin
        if (!mem_en && (mem_addr != '0 || mem_wdata != 32'h0)) nviol++;
        if (!rsp_valid && (rsp_rdata != 32'h0 || rsp_err)) nviol++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [2:0] ctrl,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int waits, output int lat,
                          output logic [31:0] rd, output logic err);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wd;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_ctrl  = 3'b111;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hDEAD_BEEF;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    initial begin
        int w, l, r0, w0;
        logic [31:0] rd;
        logic e;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[1] = 32'h8899AABB;
        mem_rdata = 32'h0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_ctrl = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        r0 = nrd;
        do_req(1'b0, 3'b000, 32'h5, 32'h0, w, l, rd, e);
        check("ldB_lat", l, 3);
        check("ldB_data", rd, 32'hFFFFFFAA);
        check("ldB_err", {31'h0, e}, 32'h0);
        check("ldB_reads", nrd - r0, 1);

        do_req(1'b0, 3'b101, 32'h6, 32'h0, w, l, rd, e);
        check("ldHU_data", rd, 32'h00008899);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, w, l, rd, e);
        check("ldW_data", rd, 32'h8899AABB);
        do_req(1'b0, 3'b001, 32'h4, 32'h0, w, l, rd, e);
        check("ldH_data", rd, 32'hFFFFAABB);
        do_req(1'b0, 3'b100, 32'h7, 32'h0, w, l, rd, e);
        check("ldBU_data", rd, 32'h00000088);

        r0 = nrd;
        w0 = nwr;
        do_req(1'b1, 3'b000, 32'h7, 32'h12345677, w, l, rd, e);
        check("stB_lat", l, 4);
        check("stB_rdata", rd, 32'h0);
        check("stB_err", {31'h0, e}, 32'h0);
        check("stB_reads", nrd - r0, 1);
        check("stB_writes", nwr - w0, 1);
        check("stB_mem", mem[1], 32'h7799AABB);

        r0 = nrd;
        w0 = nwr;
        do_req(1'b0, 3'b010, 32'h6, 32'h0, w, l, rd, e);
        check("errW_lat", l, 1);
        check("errW_err", {31'h0, e}, 32'h1);
        check("errW_rdata", rd, 32'h0);
        check("errW_memops", (nrd - r0) + (nwr - w0), 0);
        do_req(1'b1, 3'b100, 32'h4, 32'h0, w, l, rd, e);
        check("errStBU", {31'h0, e}, 32'h1);
        do_req(1'b0, 3'b011, 32'h4, 32'h0, w, l, rd, e);
        check("errCtrl", {31'h0, e}, 32'h1);
        do_req(1'b0, 3'b010, 32'h1004, 32'h0, w, l, rd, e);
        check("errRange", {31'h0, e}, 32'h1);
        do_req(1'b0, 3'b001, 32'h5, 32'h0, w, l, rd, e);
        check("errHodd", {31'h0, e}, 32'h1);

        w0 = nwr;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr = 1'b1;
        req_ctrl = 3'b001;
        req_addr = 32'h4;
        req_wdata = 32'h0000CAFE;
        while (!req_ready) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid_ready", {31'h0, req_ready}, 32'h1);
        e = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rsp_valid) e = 1'b1;
        end
        check("rstmid_norsp", {31'h0, e}, 32'h0);
        check("rstmid_writes", nwr - w0, 0);
        check("rstmid_mem", mem[1], 32'h7799AABB);

        do_req(1'b1, 3'b010, 32'h4, 32'h01020304, w, l, rd, e);
        check("stW_lat", l, 2);
        check("stW_mem", mem[1], 32'h01020304);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, w, l, rd, e);
        check("b2b_waits", w, 1);
        check("b2b_lat", l, 3);
        check("b2b_data", rd, 32'h01020304);

        @(posedge clk);
        #1;
        check("pulse_end", {31'h0, rsp_valid}, 32'h0);
        check("idle_zero_viol", nviol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 10: word-address width of the attached data SRAM (2^MEM_AW words of 32 bits).
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  access request present.
REQ-006 req_ready  out  1  unit can accept a request this cycle.
REQ-007 req_wr  in  1  1 = store, 0 = load (DMWr from the control unit).
REQ-008 req_ctrl  in  3  DMCtrl: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  32  byte address (ALU result).
REQ-010 req_wdata  in  32  store data (rs2), low bits used for B/H.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  qualifies rsp_valid: access rejected.
REQ-014 mem_en  out  1  SRAM access enable.
REQ-015 mem_we  out  1  SRAM write enable, meaningful only with mem_en.
REQ-016 mem_addr  out  MEM_AW  SRAM word address = captured req_addr[MEM_AW+1:2].
REQ-017 mem_wdata  out  32  SRAM write word.
REQ-018 mem_rdata  in  32  SRAM read word, valid the cycle after mem_en=1, mem_we=0.

Function
REQ-019 Request accepted iff req_valid && req_ready; all req_* fields captured on acceptance; req_* ignored at other times.
REQ-020 req_ready SHALL be 1 only in state IDLE.
REQ-021 States: IDLE, ACC, DATA, WR, RESP.
REQ-022 IDLE -> ACC on acceptance of a legal request; IDLE -> RESP with error flag set on acceptance of an illegal request (no SRAM access).
REQ-023 Illegal: ctrl in {011,110,111}; store with ctrl 100/101; H/HU with addr[0]=1; W with addr[1:0]!=0; addr[31:MEM_AW+2] nonzero.
REQ-024 ACC: mem_en=1; word store drives mem_we=1, mem_wdata=req_wdata, -> RESP; loads and B/H stores drive mem_we=0, -> DATA.
REQ-025 DATA, load: select byte lane addr[1:0] (B/BU) or half-word lane addr[1] (H/HU), sign-extend (B,H) or zero-extend (BU,HU), W passes word; capture into rsp_rdata; -> RESP.
REQ-026 DATA, B/H store: merge req_wdata[7:0] / [15:0] into mem_rdata at selected lane, other bytes unchanged; -> WR.
REQ-027 WR: mem_en=1, mem_we=1, mem_wdata=merged word; -> RESP.
REQ-028 RESP: rsp_valid=1 exactly one cycle, rsp_err per captured flag; -> IDLE. No response backpressure.
REQ-029 Latency acceptance-to-rsp_valid: error 1 cycle; word store 2; load 3; B/H store 4.
REQ-030 mem_en=0 in IDLE, DATA, RESP; mem_addr, mem_wdata SHALL be 0 when mem_en=0.
REQ-031 rsp_rdata, rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-032 Back-to-back: a new request is acceptable the cycle after RESP (IDLE); no overlap of accesses.

Reset
REQ-033 rst=1 at a clock edge forces IDLE and clears all captured fields; outputs next cycle: req_ready=1, all others 0.
REQ-034 Reset mid-operation abandons the access; a B/H store reset before WR SHALL leave SRAM unmodified.

Structure
REQ-035 Package dm_pkg SHALL hold the DMCtrl encodings, state enum, and lane-select helpers' width constants.
REQ-036 Sub-module dm_byte_lane (combinational): load extraction/extension and store merge, instantiated once.

Verification (SRAM model, word 1 preloaded 0x8899AABB)
REQ-037 Load B addr 0x5 -> rsp_valid 3 cycles after accept, rsp_rdata 0xFFFFFFAA, rsp_err 0.
REQ-038 Load HU addr 0x6 -> rsp_rdata 0x00008899; load W addr 0x4 -> 0x8899AABB.
REQ-039 Store B addr 0x7 wdata 0x12345677 -> rsp_valid at cycle 4, word 1 becomes 0x7799AABB; one read then one write on SRAM.
REQ-040 Load W addr 0x6 -> rsp_valid 1 cycle after accept, rsp_err 1, rsp_rdata 0, mem_en never 1.
REQ-041 Store H addr 0x4 wdata 0xCAFE, rst asserted in DATA -> IDLE next cycle, word 1 unchanged, no rsp_valid.
REQ-042 Store W addr 0x4 wdata 0x01020304 immediately followed by load W addr 0x4 -> second request accepted cycle after first RESP, returns 0x01020304.
